fb_sram_port: RTL
=================

FB_SRAM_PORT -- requirements
Module: fb_sram_port

Interface
REQ-001 SHALL have parameter DW, default 16, meaning pixel width in bits (1..16, LSB-aligned on SRAM_DQ).
REQ-002 SHALL have parameter SCALE_SHIFT, default 1, meaning log2 of screen pixels per framebuffer pixel per axis (1..2).
REQ-003 SHALL have parameter X_BITS, default 9, and Y_BITS, default 9, meaning framebuffer address bits per axis (X_BITS+Y_BITS <= 18).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning write FIFO entries (power of 2, >= 2).
REQ-005 SHALL have parameter CLEAR_COLOR, default 0, meaning the DW-bit value written by a clear.
REQ-006 Ports (name  direction  width  meaning):
- iCLK  in  1  single clock (VGA control clock); every register samples on its rising edge.
- iRST_N  in  1  reset, asynchronous, active-low.
- iCoord_X / iCoord_Y  in  10 each  display scan coordinates.
- iActive  in  1  coordinates are inside the visible area.
- iWr_valid  in  1  write request.
- iWr_addr  in  X_BITS+Y_BITS  {x,y} framebuffer address.
- iWr_data  in  DW  pixel value.
- oWr_ready  out  1  FIFO not full.
- iClear  in  1  start full-framebuffer clear.
- oClear_busy  out  1  clear in progress.
- oPixel  out  DW  pixel read for the display.
- oPixel_valid  out  1  oPixel updated this cycle.
- oLevel  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- oOverflow  out  1  sticky dropped-write flag.
- SRAM_ADDR  out  18.
- SRAM_DQ  inout  16.
- SRAM_WE_N  out  1.
- SRAM_OE_N  out  1.

Function
REQ-007 Display address SHALL be {iCoord_X[SCALE_SHIFT+X_BITS-1:SCALE_SHIFT], iCoord_Y[SCALE_SHIFT+Y_BITS-1:SCALE_SHIFT]}, zero-extended to 18 bits; x occupies the upper bits.
REQ-008 Cycle n SHALL be a read slot when iActive=1 and iCoord_X[0]=0; every other cycle SHALL be a write slot.
REQ-009 SRAM_ADDR, SRAM_WE_N and SRAM_OE_N SHALL be registered: the slot decided in cycle n drives the SRAM during cycle n+1.
REQ-010 Read slot: in n+1, OE_N=0, WE_N=1, SRAM_DQ hi-Z and SRAM_ADDR = display address; SRAM_DQ[DW-1:0] SHALL be registered into oPixel at the end of n+1, with oPixel_valid=1 for exactly cycle n+2.
REQ-011 Display latency coordinate->oPixel SHALL be exactly 2 cycles; when no read occurs, oPixel SHALL hold its value and oPixel_valid=0.
REQ-012 Write slot: the source priority SHALL be clear (if busy), then FIFO head (if non-empty), else idle with WE_N=1, OE_N=1 and DQ hi-Z.
REQ-013 SRAM write in n+1: WE_N=0, OE_N=1, SRAM_DQ = {zeros, data} driven only in that cycle.
REQ-014 FIFO SHALL accept a push when iWr_valid=1 and the registered level < FIFO_DEPTH at cycle start; a pop in the same cycle SHALL NOT make a full FIFO accept.
REQ-015 oWr_ready SHALL be (level < FIFO_DEPTH); simultaneous accepted push and pop SHALL leave the level unchanged; push to an empty FIFO SHALL NOT be popped in the same cycle.
REQ-016 iWr_valid=1 while full SHALL drop the write and set oOverflow, which stays 1 until reset.
REQ-017 Clear FSM states SHALL be IDLE and CLEAR: IDLE->CLEAR on iClear=1; counter cleared to 0; oClear_busy=1 in CLEAR.
REQ-018 In CLEAR, each write slot SHALL write CLEAR_COLOR at the counter address and then increment it; after address 2^(X_BITS+Y_BITS)-1 is written the FSM SHALL return to IDLE.
REQ-019 iClear during CLEAR SHALL be ignored; FIFO entries SHALL be retained during CLEAR while pushes continue to be accepted.
REQ-020 The FIFO and clear counter SHALL wrap modulo their sizes without error.

Reset
REQ-021 iRST_N=0 SHALL immediately give: SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, SRAM_DQ hi-Z, oPixel=0, oPixel_valid=0, FIFO empty (oLevel=0, oWr_ready=1), Clear FSM in IDLE with oClear_busy=0, oOverflow=0.
REQ-022 Reset during CLEAR or an SRAM write SHALL abort it; after release, no write SHALL occur without new requests.

Verification
REQ-023 iActive=1, X=4, Y=6, SRAM model holds 0xABCD at address {9'd2,9'd3} -> SRAM_ADDR=0x00403 and OE_N=0 at n+1; oPixel=0xABCD with oPixel_valid=1 at n+2.
REQ-024 iActive=0, push addr 0x00010 data 0x1234 -> WE_N=0, SRAM_ADDR=0x00010, DQ=0x1234 two cycles later; oLevel returns to 0.
REQ-025 iActive=1, 9 back-to-back pushes into FIFO_DEPTH=8 with no slot yet drained -> 9th dropped, oWr_ready=0 at level 8, oOverflow=1 and sticky.
REQ-026 Set X_BITS=Y_BITS=2 and pulse iClear -> 16 writes of CLEAR_COLOR to addresses 0..15 in write slots; oClear_busy falls after the last; a queued FIFO write follows.
REQ-027 Assert iRST_N=0 mid-clear with a FIFO level of 3 -> all REQ-021 values immediately; no SRAM write after release.
REQ-028 Alternate iCoord_X[0] with iActive=1 and the FIFO non-empty -> reads and writes interleave every cycle; a pixel read never coincides with WE_N=0.

Source files
------------

// File: rtl/fb_sram_port.sv
// fb_sram_port: single-clock framebuffer SRAM arbiter. Display reads take
// even-x visible cycles; all other cycles are write slots, which serve a
// full-framebuffer clear first and a small write FIFO second.
module fb_sram_port #(
    parameter int             DW          = 16,
    parameter int             SCALE_SHIFT = 1,
    parameter int             X_BITS      = 9,
    parameter int             Y_BITS      = 9,
    parameter int             FIFO_DEPTH  = 8,
    parameter logic [DW-1:0]  CLEAR_COLOR = '0
) (
    input  logic                                iCLK,
    input  logic                                iRST_N,
    input  logic [9:0]                          iCoord_X,
    input  logic [9:0]                          iCoord_Y,
    input  logic                                iActive,
    input  logic                                iWr_valid,
    input  logic [X_BITS+Y_BITS-1:0]            iWr_addr,
    input  logic [DW-1:0]                       iWr_data,
    output logic                                oWr_ready,
    input  logic                                iClear,
    output logic                                oClear_busy,
    output logic [DW-1:0]                       oPixel,
    output logic                                oPixel_valid,
    output logic [$clog2(FIFO_DEPTH):0]         oLevel,
    output logic                                oOverflow,
    output logic [17:0]                         SRAM_ADDR,
    inout  wire  [15:0]                         SRAM_DQ,
    output logic                                SRAM_WE_N,
    output logic                                SRAM_OE_N
);

    localparam int AW = X_BITS + Y_BITS;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {IDLE, CLEAR} clrState_t;

    clrState_t          clrState_q, clrState_d;
    logic [AW-1:0]      clrCnt_q, clrCnt_d;

    logic [AW+DW-1:0]   fifoMem_q [FIFO_DEPTH];
    logic [PW-1:0]      wrPtr_q, rdPtr_q;
    logic [LW-1:0]      level_q, level_d;
    logic               overflow_q;

    logic [17:0]        sramAddr_q, sramAddr_d;
    logic               weN_q, weN_d;
    logic               oeN_q, oeN_d;
    logic               dqOe_q, dqOe_d;
    logic [15:0]        dqOut_q, dqOut_d;
    logic               readPend_q, readPend_d;
    logic [DW-1:0]      pixel_q;
    logic               pixelValid_q;

    logic               readSlot;
    logic               writeSlot;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               pushOk;
    logic               popOk;
    logic               clrWrite;
    logic [AW+DW-1:0]   headEntry;
    logic [17:0]        dispAddr;

    // Coordinate bits below the scale factor, above the framebuffer range and
    // the SRAM data bits above DW carry no information for this port.
    wire unusedBits = &{1'b0, iCoord_X, iCoord_Y, SRAM_DQ};

    assign readSlot  = iActive & ~iCoord_X[0];
    assign writeSlot = ~readSlot;
    assign fifoFull  = (level_q == LW'(FIFO_DEPTH));
    assign fifoEmpty = (level_q == '0);
    assign pushOk    = iWr_valid & ~fifoFull;
    assign clrWrite  = writeSlot & (clrState_q == CLEAR);
    assign popOk     = writeSlot & (clrState_q != CLEAR) & ~fifoEmpty;
    assign headEntry = fifoMem_q[rdPtr_q];
    assign dispAddr  = 18'({iCoord_X[SCALE_SHIFT+X_BITS-1:SCALE_SHIFT],
                            iCoord_Y[SCALE_SHIFT+Y_BITS-1:SCALE_SHIFT]});

    assign oWr_ready    = ~fifoFull;
    assign oClear_busy  = (clrState_q == CLEAR);
    assign oLevel       = level_q;
    assign oOverflow    = overflow_q;
    assign oPixel       = pixel_q;
    assign oPixel_valid = pixelValid_q;
    assign SRAM_ADDR    = sramAddr_q;
    assign SRAM_WE_N    = weN_q;
    assign SRAM_OE_N    = oeN_q;
    assign SRAM_DQ      = dqOe_q ? dqOut_q : 16'bz;

    // Clear sequencer: walk every framebuffer address once, one per write slot.
    always_comb begin
        clrState_d = clrState_q;
        clrCnt_d   = clrCnt_q;
        case (clrState_q)
            IDLE: begin
                if (iClear) begin
                    clrState_d = CLEAR;
                    clrCnt_d   = '0;
                end
            end
            CLEAR: begin
                if (clrWrite) begin
                    clrCnt_d = clrCnt_q + AW'(1);
                    if (clrCnt_q == '1) begin
                        clrState_d = IDLE;
                    end
                end
            end
            default: clrState_d = IDLE;
        endcase
    end

    // Clear sequencer state register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            clrState_q <= IDLE;
            clrCnt_q   <= '0;
        end else begin
            clrState_q <= clrState_d;
            clrCnt_q   <= clrCnt_d;
        end
    end

    // Slot decision for the next cycle's SRAM bus: read, clear write, FIFO write or idle.
    always_comb begin
        sramAddr_d = sramAddr_q;
        weN_d      = 1'b1;
        oeN_d      = 1'b1;
        dqOe_d     = 1'b0;
        dqOut_d    = dqOut_q;
        readPend_d = 1'b0;
        if (readSlot) begin
            sramAddr_d = dispAddr;
            oeN_d      = 1'b0;
            readPend_d = 1'b1;
        end else if (clrWrite) begin
            sramAddr_d = 18'(clrCnt_q);
            weN_d      = 1'b0;
            dqOe_d     = 1'b1;
            dqOut_d    = 16'(CLEAR_COLOR);
        end else if (popOk) begin
            sramAddr_d = 18'(headEntry[AW+DW-1:DW]);
            weN_d      = 1'b0;
            dqOe_d     = 1'b1;
            dqOut_d    = 16'(headEntry[DW-1:0]);
        end
    end

    // SRAM control and data-out registers; reset parks the bus idle and tri-stated.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sramAddr_q <= '0;
            weN_q      <= 1'b1;
            oeN_q      <= 1'b1;
            dqOe_q     <= 1'b0;
            dqOut_q    <= '0;
            readPend_q <= 1'b0;
        end else begin
            sramAddr_q <= sramAddr_d;
            weN_q      <= weN_d;
            oeN_q      <= oeN_d;
            dqOe_q     <= dqOe_d;
            dqOut_q    <= dqOut_d;
            readPend_q <= readPend_d;
        end
    end

    // Capture read data at the end of the read cycle; hold it otherwise.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pixel_q      <= '0;
            pixelValid_q <= 1'b0;
        end else begin
            if (readPend_q) begin
                pixel_q <= SRAM_DQ[DW-1:0];
            end
            pixelValid_q <= readPend_q;
        end
    end

    // FIFO storage has no reset; only entries below the level are ever read.
    always_ff @(posedge iCLK) begin
        if (pushOk) begin
            fifoMem_q[wrPtr_q] <= {iWr_addr, iWr_data};
        end
    end

    // Occupancy follows accepted pushes and pops against the registered level.
    always_comb begin
        level_d = level_q;
        case ({pushOk, popOk})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO pointers, level and the sticky overflow flag.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            level_q <= level_d;
            if (iWr_valid && fifoFull) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule
